// File: rtl/async_queue_pkg.sv
// Shared definitions for the clock-domain-crossing queue: Gray coding, full-compare mask and
// the default synchronizer depth.
package async_queue_pkg;

  localparam int unsigned DefaultSyncDepth = 3;
  localparam int unsigned MaxIdxWidth      = 32;

  function automatic logic [MaxIdxWidth-1:0] bin2gray(input logic [MaxIdxWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray(x + depth) == Gray(x) ^ mask: the two index MSBs inverted, lower bits equal.
  function automatic logic [MaxIdxWidth-1:0] full_mask(input int unsigned depth_log2);
    logic [MaxIdxWidth-1:0] base;
    base = {{(MaxIdxWidth-2){1'b0}}, 2'b11};
    return base << (depth_log2 - 1);
  endfunction

endpackage

// File: rtl/async_reset_sync_chain.sv
// Multi-flop synchronizer, WIDTH bits wide and SYNC_DEPTH flops long, async active-low reset.
module async_reset_sync_chain
  import async_queue_pkg::*;
#(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned SYNC_DEPTH = DefaultSyncDepth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[SYNC_DEPTH-1];

endmodule

// File: rtl/async_queue_source.sv
// Enqueue half of the async queue: flop-array ring, Gray write index out, synchronized Gray
// read index and sink-valid in, ready derived from registered state only.
module async_queue_source
  import async_queue_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned SYNC_DEPTH = DefaultSyncDepth
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             io_enq_valid,
  output logic                             io_enq_ready,
  input  logic [WIDTH-1:0]                 io_enq_bits,
  output logic [WIDTH*(2**DEPTH_LOG2)-1:0] io_async_mem,
  output logic [DEPTH_LOG2:0]              io_async_widx,
  input  logic [DEPTH_LOG2:0]              io_async_ridx,
  output logic                             io_async_safe_widx_valid,
  input  logic                             io_async_safe_ridx_valid
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned IdxW  = DEPTH_LOG2 + 1;
  localparam logic [IdxW-1:0] FullMask = IdxW'(full_mask(DEPTH_LOG2));

  logic [IdxW-1:0]  widx_bin_q, widx_bin_d;
  logic [IdxW-1:0]  widx_gray_q, widx_gray_d;
  logic [WIDTH-1:0] mem_q [Depth];
  logic [Depth-1:0] mem_we;
  logic             safe_widx_valid_q;
  logic [IdxW-1:0]  ridx_sync;
  logic             sink_ok;
  logic             full;
  logic             fire;

  async_reset_sync_chain #(
    .WIDTH      (IdxW),
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_ridx_sync (
    .clock (clock),
    .reset (reset),
    .d     (io_async_ridx),
    .q     (ridx_sync)
  );

  async_reset_sync_chain #(
    .WIDTH      (1),
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_sink_valid_sync (
    .clock (clock),
    .reset (reset),
    .d     (io_async_safe_ridx_valid),
    .q     (sink_ok)
  );

  assign full         = (widx_gray_q == (ridx_sync ^ FullMask));
  assign io_enq_ready = sink_ok & ~full;
  assign fire         = io_enq_valid & io_enq_ready;

  always_comb begin
    widx_bin_d = widx_bin_q;
    if (!sink_ok) begin
      widx_bin_d = '0;
    end else if (fire) begin
      widx_bin_d = widx_bin_q + 1'b1;
    end
    widx_gray_d = IdxW'(bin2gray(MaxIdxWidth'(widx_bin_d)));
  end

  always_comb begin
    mem_we = '0;
    for (int i = 0; i < Depth; i++) begin
      mem_we[i] = fire && (widx_bin_q[DEPTH_LOG2-1:0] == DEPTH_LOG2'(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      widx_bin_q        <= '0;
      widx_gray_q       <= '0;
      safe_widx_valid_q <= 1'b0;
    end else begin
      widx_bin_q        <= widx_bin_d;
      widx_gray_q       <= widx_gray_d;
      safe_widx_valid_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < Depth; g++) begin : gen_mem
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        mem_q[g] <= '0;
      end else if (mem_we[g]) begin
        mem_q[g] <= io_enq_bits;
      end
    end
    assign io_async_mem[g*WIDTH +: WIDTH] = mem_q[g];
  end

  assign io_async_widx            = widx_gray_q;
  assign io_async_safe_widx_valid = safe_widx_valid_q;

endmodule

// File: doc/async_queue_source.md
# async_queue_source

Enqueue half of the clock-domain-crossing queue. It accepts a ready/valid stream in the source clock domain and writes it into a register-file ring. It publishes a Gray-coded write index plus a source-valid flag to the sink half. The sink's `safe_widx_valid` input is synchronized by the sink-side valid synchronizer. In return, this block synchronizes the sink's Gray read index and sink-valid flag back into its own domain to compute `io_enq_ready`.

## Interface
- `WIDTH`, 32: payload bits per entry.
- `DEPTH_LOG2`, 3: log2 of entry count; depth = 2^DEPTH_LOG2 (8).
- `SYNC_DEPTH`, 3: flops per synchronizer chain.

- `clock` input 1: source-domain clock, the only clock.
- `reset` input 1: asynchronous, active-low reset.
- `io_enq_valid` input 1: producer has data.
- `io_enq_ready` output 1: entry accepted on this edge if valid.
- `io_enq_bits` input WIDTH: payload.
- `io_async_mem` output WIDTH*2^DEPTH_LOG2: flattened ring; entry i at bits [i*WIDTH +: WIDTH].
- `io_async_widx` output DEPTH_LOG2+1: Gray write index.
- `io_async_ridx` input DEPTH_LOG2+1: Gray read index from the sink domain (asynchronous).
- `io_async_safe_widx_valid` output 1: source-valid flag to the sink.
- `io_async_safe_ridx_valid` input 1: sink-valid flag from the sink domain (asynchronous).

## Operation
- `widx_bin` is a DEPTH_LOG2+1-bit binary counter. `widx_gray = widx_bin ^ (widx_bin >> 1)`, registered and driven on `io_async_widx`.
- `ridx_sync`: `io_async_ridx` passed through a SYNC_DEPTH-flop synchronizer, one chain per bit.
- `sink_ok`: `io_async_safe_ridx_valid` passed through a SYNC_DEPTH-flop synchronizer.
- `full` is true when `widx_gray == ridx_sync ^ {2'b11, {DEPTH_LOG2-1{1'b0}}}`. That is, the two MSBs are inverted and the remaining bits are equal.
- `io_enq_ready = sink_ok & ~full`. It is a function of registers only and never depends on `io_enq_valid`.
- On fire (`valid & ready`):
  - `mem[widx_bin[DEPTH_LOG2-1:0]] <= io_enq_bits`.
  - `widx_bin <= widx_bin + 1`, wrapping modulo 2^(DEPTH_LOG2+1).
  - The Gray register updates on the same edge.
- When `sink_ok == 0`, `widx_bin` and the Gray register synchronously clear to 0. Memory contents are untouched.
- `io_async_safe_widx_valid` is a flop that resets to 0 and sets to 1 on the first clock edge after `reset` deasserts.

## Timing
- All outputs are 0 while `reset` is low: ready, widx, safe_widx_valid, and every mem entry. Synchronizer flops also reset to 0.
- Reset assertion takes effect immediately, without a clock edge, including mid-transfer. Entries accepted earlier are discarded from this block's view.
- Enqueue to widx visibility: the write and the widx increment occur on the same edge. Entry data is stable before the sink can observe the new index through its SYNC_DEPTH-flop synchronizer.
- Sink ridx change to ready: SYNC_DEPTH edges of synchronizer delay, then combinational.
- Full boundary: after 2^DEPTH_LOG2 accepts with no ridx advance, ready drops in the same cycle the last accept's edge updates widx.
- Simultaneous fire and ridx advance: the fire is evaluated against the pre-edge `ridx_sync`, which is conservative.
- Sink-valid drop: ready falls SYNC_DEPTH edges after the input falls, and widx clears on the edge after `sink_ok` falls. When `io_async_safe_ridx_valid` rises again, ready returns SYNC_DEPTH edges later.
- Wrap-around: the counter is modulo 2·depth, so Gray full/empty comparisons stay unambiguous.

## Structure
- A shared package `async_queue_pkg` holds:
  - the `bin2gray` function;
  - a function that computes the full-compare mask from DEPTH_LOG2;
  - the default SYNC_DEPTH constant.
- One sub-module, `async_reset_sync_chain`: a parameterized width×SYNC_DEPTH shift register with asynchronous active-low reset to 0. It is instantiated twice: once for ridx (width DEPTH_LOG2+1) and once for sink-valid (width 1).
- Memory is a flop array with per-entry write enables. No RAM macro is used.

## Test plan
- Reset: hold `reset` low with random inputs. Required: ready=0, widx=0, safe_widx_valid=0, all mem entries 0. Release reset and drive ridx_valid=1. Required: safe_widx_valid=1 one edge after release, and ready=1 three edges after sink-valid reaches the input.
- Fill: hold ridx=0, drive valid with bits 0xA0..0xA7. Required: 8 accepts, mem[i]=0xA0+i, widx Gray=4'b1100, ready=0 and the 9th word is not accepted.
- Drain one: from the full state, set ridx=Gray(1)=4'b0001. Required: ready=1 exactly 3 edges later; one more accept, after which widx=Gray(9)=4'b1101.
- Wrap: 20 writes with ridx tracking widx after a 3-cycle lag. Required: widx counts Gray 0..15 then wraps to 0, and data lands at index `count mod 8`.
- Sink reset mid-stream: after 5 writes, drop ridx_valid. Required: ready=0 by edge 3, widx=0 on the next edge, mem unchanged. Restore ridx_valid. Required: ready returns after 3 edges and the next write goes to mem[0].
- Async reset mid-fill: assert `reset` between clock edges. Required: all outputs 0 immediately, with no clock edge needed.
